// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard shared constants.
// Widths, zero word and reset polarity.
package regfile_scoreboard_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = $clog2(NREG);

  localparam logic [XLEN-1:0] ZERO = '0;
  localparam logic RST_ACT = 1'b1;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode, writeback, flush and debug bundle
// between the pipeline and the register file.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
();

  logic            id_valid;
  logic            id_rs1_use;
  logic            id_rs2_use;
  logic [AW-1:0]   id_rs1_addr;
  logic [AW-1:0]   id_rs2_addr;
  logic            id_rd_ena;
  logic [AW-1:0]   id_rd_addr;
  logic            id_stall;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_valid;
  logic            wb_rd_ena;
  logic [AW-1:0]   wb_rd_addr;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output id_valid, id_rs1_use, id_rs2_use,
    output id_rs1_addr, id_rs2_addr,
    output id_rd_ena, id_rd_addr,
    output wb_valid, wb_rd_ena, wb_rd_addr,
    output wb_data, flush, dbg_addr,
    input  id_stall, rs1_data, rs2_data,
    input  dbg_data
  );

  modport slave (
    input  id_valid, id_rs1_use, id_rs2_use,
    input  id_rs1_addr, id_rs2_addr,
    input  id_rd_ena, id_rd_addr,
    input  wb_valid, wb_rd_ena, wb_rd_addr,
    input  wb_data, flush, dbg_addr,
    output id_stall, rs1_data, rs2_data,
    output dbg_data
  );

endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Pending-writer counter for one register.
// Decrement is ignored at zero so stale retires never underflow.
module sb_counter
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             at_max
);

  logic dec_ok;

  assign nonzero = (count != '0);
  assign at_max  = (count == {CNT_W{1'b1}});
  assign dec_ok  = dec & nonzero;

  // reset/flush clear; simultaneous inc and dec cancel
  always_ff @(posedge clk) begin
    if (rst == RST_ACT || clr) begin
      count <= '0;
    end else if (inc && !dec_ok) begin
      count <= count + 1'b1;
    end else if (!inc && dec_ok) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with writeback bypass and
// per-register pending-write scoreboard driving decode stall.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  logic [XLEN-1:0] rf [NREG];

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            nz;
  logic [NREG-1:0]            at_max;

  logic wb_fire;
  logic byp1, byp2;
  logic hz1, hz2, sat;
  logic issue_fire;

  assign wb_fire = bus.wb_valid & bus.wb_rd_ena
                 & (bus.wb_rd_addr != '0);

  assign byp1 = wb_fire
              & (bus.wb_rd_addr == bus.id_rs1_addr);
  assign byp2 = wb_fire
              & (bus.wb_rd_addr == bus.id_rs2_addr);

  // source reads: x0 hardwired, then bypass, then array
  always_comb begin
    bus.rs1_data = rf[bus.id_rs1_addr];
    bus.rs2_data = rf[bus.id_rs2_addr];
    if (byp1)
      bus.rs1_data = bus.wb_data;
    if (byp2)
      bus.rs2_data = bus.wb_data;
    if (bus.id_rs1_addr == '0)
      bus.rs1_data = ZERO;
    if (bus.id_rs2_addr == '0)
      bus.rs2_data = ZERO;
  end

  assign bus.dbg_data = (bus.dbg_addr == '0)
                      ? ZERO : rf[bus.dbg_addr];

  // a lone pending writer retiring now is covered by bypass
  assign hz1 = bus.id_rs1_use
             & (bus.id_rs1_addr != '0)
             & nz[bus.id_rs1_addr]
             & ~((cnt[bus.id_rs1_addr] == CNT_W'(1))
                 & byp1);

  assign hz2 = bus.id_rs2_use
             & (bus.id_rs2_addr != '0)
             & nz[bus.id_rs2_addr]
             & ~((cnt[bus.id_rs2_addr] == CNT_W'(1))
                 & byp2);

  assign sat = bus.id_rd_ena
             & (bus.id_rd_addr != '0)
             & at_max[bus.id_rd_addr]
             & ~(wb_fire
                 & (bus.wb_rd_addr == bus.id_rd_addr));

  assign bus.id_stall = bus.id_valid & (hz1 | hz2 | sat);

  assign issue_fire = bus.id_valid & ~bus.id_stall
                    & bus.id_rd_ena
                    & (bus.id_rd_addr != '0)
                    & ~bus.flush;

  // array update; retiring writes survive a flush
  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= ZERO;
    end else if (wb_fire) begin
      rf[bus.wb_rd_addr] <= bus.wb_data;
    end
  end

  assign cnt[0]    = '0;
  assign nz[0]     = 1'b0;
  assign at_max[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    logic inc_r, dec_r;

    assign inc_r = issue_fire
                 & (bus.id_rd_addr == AW'(r));
    assign dec_r = wb_fire
                 & (bus.wb_rd_addr == AW'(r));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_r),
      .dec     (dec_r),
      .clr     (bus.flush),
      .count   (cnt[r]),
      .nonzero (nz[r]),
      .at_max  (at_max[r])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard.
// Inputs change at negedge, outputs sampled 1ns later.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid    = 1'b0;
    bus.id_rs1_use  = 1'b0;
    bus.id_rs2_use  = 1'b0;
    bus.id_rs1_addr = '0;
    bus.id_rs2_addr = '0;
    bus.id_rd_ena   = 1'b0;
    bus.id_rd_addr  = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd_ena   = 1'b0;
    bus.wb_rd_addr  = '0;
    bus.wb_data     = '0;
    bus.flush       = 1'b0;
    bus.dbg_addr    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.id_valid   = 1'b1;
    bus.id_rd_ena  = 1'b1;
    bus.id_rd_addr = rd;
  endtask

  task automatic use1(input logic [4:0] rs);
    bus.id_valid    = 1'b1;
    bus.id_rs1_use  = 1'b1;
    bus.id_rs1_addr = rs;
  endtask

  task automatic wb(input logic [4:0] rd,
                    input logic [31:0] d);
    bus.wb_valid   = 1'b1;
    bus.wb_rd_ena  = 1'b1;
    bus.wb_rd_addr = rd;
    bus.wb_data    = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.id_stall), 32'd0);
    chk("rst_rs1", bus.rs1_data, 32'd0);

    // 1: clean read after reset
    bus.id_valid    = 1'b1;
    bus.id_rs1_use  = 1'b1;
    bus.id_rs2_use  = 1'b1;
    bus.id_rs1_addr = 5'd5;
    bus.id_rs2_addr = 5'd6;
    bus.dbg_addr    = 5'd5;
    #1;
    chk("t1_stall", 32'(bus.id_stall), 32'd0);
    chk("t1_rs1", bus.rs1_data, 32'd0);
    chk("t1_rs2", bus.rs2_data, 32'd0);
    chk("t1_dbg5", bus.dbg_data, 32'd0);
    tick();

    // 2: RAW stall and bypass release
    issue(5'd5);
    #1;
    chk("t2_issue", 32'(bus.id_stall), 32'd0);
    tick();
    use1(5'd5);
    #1;
    chk("t2_raw", 32'(bus.id_stall), 32'd1);
    wb(5'd5, 32'hDEADBEEF);
    #1;
    chk("t2_byp_stall", 32'(bus.id_stall), 32'd0);
    chk("t2_byp_data", bus.rs1_data, 32'hDEADBEEF);
    tick();
    use1(5'd5);
    bus.dbg_addr = 5'd5;
    #1;
    chk("t2_cnt0", 32'(bus.id_stall), 32'd0);
    chk("t2_reg5", bus.dbg_data, 32'hDEADBEEF);
    chk("t2_rs1", bus.rs1_data, 32'hDEADBEEF);
    tick();

    // 3: saturation of x7
    for (int k = 0; k < 3; k++) begin
      issue(5'd7);
      tick();
    end
    issue(5'd7);
    #1;
    chk("t3_sat", 32'(bus.id_stall), 32'd1);
    wb(5'd7, 32'h700);
    #1;
    chk("t3_sat_wb", 32'(bus.id_stall), 32'd0);
    tick();
    issue(5'd7);
    #1;
    chk("t3_still3", 32'(bus.id_stall), 32'd1);
    tick();
    wb(5'd7, 32'h701);
    tick();
    wb(5'd7, 32'h702);
    tick();
    use1(5'd7);
    #1;
    chk("t3_cnt1", 32'(bus.id_stall), 32'd1);
    wb(5'd7, 32'h703);
    #1;
    chk("t3_last_byp", 32'(bus.id_stall), 32'd0);
    chk("t3_last_data", bus.rs1_data, 32'h703);
    tick();
    use1(5'd7);
    #1;
    chk("t3_drained", 32'(bus.id_stall), 32'd0);
    tick();

    // 4: x0 is inert
    issue(5'd0);
    wb(5'd0, 32'h1234);
    tick();
    use1(5'd0);
    bus.dbg_addr = 5'd0;
    #1;
    chk("t4_stall", 32'(bus.id_stall), 32'd0);
    chk("t4_rs1", bus.rs1_data, 32'd0);
    chk("t4_dbg0", bus.dbg_data, 32'd0);
    tick();

    // 5: flush with concurrent retire
    issue(5'd9);
    tick();
    issue(5'd9);
    tick();
    issue(5'd9);
    bus.flush = 1'b1;
    wb(5'd3, 32'h55);
    tick();
    use1(5'd9);
    bus.dbg_addr = 5'd3;
    #1;
    chk("t5_flush", 32'(bus.id_stall), 32'd0);
    chk("t5_reg3", bus.dbg_data, 32'h55);
    tick();
    wb(5'd9, 32'h77);
    tick();
    use1(5'd9);
    bus.dbg_addr = 5'd9;
    #1;
    chk("t5_reg9", bus.dbg_data, 32'h77);
    chk("t5_no_uflow", 32'(bus.id_stall), 32'd0);
    tick();
    issue(5'd9);
    tick();
    use1(5'd9);
    #1;
    chk("t5_cnt1", 32'(bus.id_stall), 32'd1);
    tick();

    // 6: reset mid-stream
    issue(5'd4);
    tick();
    issue(5'd4);
    tick();
    use1(5'd4);
    #1;
    chk("t6_pend", 32'(bus.id_stall), 32'd1);
    rst = 1'b1;
    wb(5'd4, 32'hAA);
    issue(5'd4);
    tick();
    rst = 1'b0;
    bus.id_valid    = 1'b1;
    bus.id_rs1_use  = 1'b1;
    bus.id_rs2_use  = 1'b1;
    bus.id_rs1_addr = 5'd4;
    bus.id_rs2_addr = 5'd9;
    bus.dbg_addr    = 5'd5;
    #1;
    chk("t6_stall", 32'(bus.id_stall), 32'd0);
    chk("t6_rs1", bus.rs1_data, 32'd0);
    chk("t6_reg5", bus.dbg_data, 32'd0);
    bus.dbg_addr = 5'd3;
    #1;
    chk("t6_reg3", bus.dbg_data, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Architectural integer register file (x0..x31) plus per-register pending-write scoreboard.
- Write side terminates the writeback interface: rd enable, rd address, rd data, retire valid.
- Read side serves the decode stage: two source reads with same-cycle writeback bypass.
- Generates the decode stall on RAW hazards and on scoreboard saturation; a pipeline flush clears all speculative pending marks.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; address width is log2(NREG).
- CNT_W, 2, pending-counter width per register; max in-flight writers per register is 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode holds an instruction requesting issue
- id_rs1_use  in  1  instruction reads rs1
- id_rs2_use  in  1  instruction reads rs2
- id_rs1_addr  in  5  source 1 address
- id_rs2_addr  in  5  source 2 address
- id_rd_ena  in  1  instruction writes rd
- id_rd_addr  in  5  destination address
- id_stall  out  1  decode must hold; issue not accepted
- rs1_data  out  XLEN  source 1 value (bypassed)
- rs2_data  out  XLEN  source 2 value (bypassed)
- wb_valid  in  1  writeback stage retires an instruction this cycle
- wb_rd_ena  in  1  retiring instruction writes rd
- wb_rd_addr  in  5  retiring destination
- wb_data  in  XLEN  retiring result
- flush  in  1  discard all non-retired in-flight instructions
- dbg_addr  in  5  debug/difftest read address
- dbg_data  out  XLEN  debug read value (no bypass, registered array only)

Behaviour:
- Reset: all registers 0, all pending counters 0. id_stall, rs1_data, rs2_data and dbg_data follow their combinational definitions: id_stall=0 when id_valid=0, and data outputs read 0.
- x0: reads always 0. Writes to x0 are ignored. Issue with rd=x0 never increments a counter.
- Write: on posedge, if wb_valid & wb_rd_ena & wb_rd_addr!=0, then reg[wb_rd_addr] <= wb_data.
- wb_fire = wb_valid & wb_rd_ena & wb_rd_addr!=0.
- Reads are combinational.
  - rsN_data = wb_data when wb_fire & wb_rd_addr==rsN_addr (bypass).
  - Otherwise rsN_data = reg[rsN_addr].
  - Always 0 when rsN_addr==0.
- Hazard for source N: rsN_use & rsN_addr!=0 & cnt[rsN_addr]!=0, except when cnt[rsN_addr]==1 & wb_fire & wb_rd_addr==rsN_addr. In that exception the bypass resolves it and there is no hazard.
- Saturation: id_rd_ena & id_rd_addr!=0 & cnt[id_rd_addr]==max & no wb_fire to id_rd_addr in that cycle.
- id_stall = id_valid & (hazard1 | hazard2 | saturation). Purely combinational, zero latency.
- issue_fire = id_valid & ~id_stall & id_rd_ena & id_rd_addr!=0 & ~flush.
- Counter update per register r, at posedge:
  - inc = issue_fire & id_rd_addr==r.
  - dec = wb_fire & wb_rd_addr==r & cnt[r]!=0.
  - inc & dec: unchanged. inc only: +1. dec only: -1.
  - A wb_fire to a register with cnt==0 (post-flush retire of an older instruction) writes data and leaves cnt at 0. It never underflows.
- Flush: at posedge all counters <= 0. Any wb_fire in the same cycle still writes the array, because the retiring instruction is committed. Issue in the flush cycle is not recorded.
- Reset mid-operation: counters and array cleared next edge. Reset dominates flush and write.
- Counters never wrap: saturation stall guarantees cnt <= 2^CNT_W-1.

Decomposition:
- Shared package/define file holds XLEN, register address width, the ZERO constant and the reset-active polarity constant.
- One natural sub-module, sb_counter: a single register's pending counter (inc, dec, clr, count, nonzero, at_max flags), instantiated NREG-1 times (x0 excluded).
- The array and bypass muxes stay in the top.

Test Plan:
1. Reset, then id_valid with rs1=5, rs2=6 used, no prior issues -> id_stall=0, rs1_data=rs2_data=0. dbg_addr=5 -> dbg_data=0.
2. Issue rd=5. Next cycle issue using rs1=5 -> id_stall=1. Then wb_valid, wb_rd_addr=5, wb_data=0xDEADBEEF in the same cycle as the stalled read -> id_stall=0, rs1_data=0xDEADBEEF. Following cycle reg[5]=0xDEADBEEF and cnt[5]=0.
3. Issue rd=7 three times (cnt=3), fourth issue rd=7 with no writeback -> id_stall=1. Same fourth issue coinciding with wb_fire rd=7 -> accepted, cnt stays 3.
4. Issue rd=0 and wb_fire with rd=0, data 0x1234 -> no stall on later rs1=0 use, rs1_data=0, dbg_data(x0)=0.
5. Issue rd=9 twice, assert flush together with wb_fire rd=3, data 0x55 -> cnt[9]=0 and reg[3]=0x55. Next-cycle read of rs1=9 does not stall. A late wb_fire rd=9 data 0x77 -> reg[9]=0x77, cnt[9] stays 0.
6. Mid-stream rst with cnt[4]=2 and wb_fire pending -> next cycle all registers 0, all counters 0, no stall on any source.
